ip_encode: RTL and testbench

- IPv4 transmit framer; the transmit-side counterpart of the nibble-stream IPv4 receive path.
- Accepts a packet request (protocol, source/destination addresses, payload length) and computes the header checksum.
- Emits a contiguous nibble stream: 20-byte header (no options) followed by payload nibbles pulled from an upstream source.
- Sits between the UDP/ICMP payload generators and the Ethernet MAC transmit framer.

---
 rtl/ip_encode.sv | 210 +++++++++++++++++++++
 tb/tb_ip_encode.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ip_encode.sv
// ip_encode -- IPv4 transmit framer (nibble stream).
//
// Latches a packet request, folds the nine non-checksum header words into a
// one's complement sum, then streams the 20-byte header (no options) followed
// by 2*payload_len payload nibbles pulled from an upstream source.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           request pulse, sampled only in IDLE
//   payload_len     payload bytes (accepted when <= 65515)
//   protocol/sa/da  IPv4 protocol, source and destination address
//   din_valid/din   upstream payload nibble, high nibble of each byte first
//   din_ready       combinational: din is consumed at the next edge
//   dout_valid/dout packet nibble stream, dout is 0 when not valid
//   busy            high in every state except IDLE
//   err             one-cycle pulse: rejected length or payload underflow
module ip_encode #(
    parameter logic [7:0]  TTL     = 8'd64,
    parameter logic        DF      = 1'b1,
    parameter logic [15:0] ID_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] payload_len,
    input  logic [7:0]  protocol,
    input  logic [31:0] sa,
    input  logic [31:0] da,
    input  logic        din_valid,
    input  logic [3:0]  din,
    output logic        din_ready,
    output logic        dout_valid,
    output logic [3:0]  dout,
    output logic        busy,
    output logic        err
);

    localparam logic [15:0] MAX_PAYLOAD = 16'd65515;

    typedef enum logic [1:0] {S_IDLE, S_CSUM, S_HDR, S_PAYLOAD} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;      // CSUM: word step 0..9, HDR: nibble 0..39
    logic [15:0] len_q, len_d;
    logic [7:0]  proto_q, proto_d;
    logic [31:0] sa_q, sa_d;
    logic [31:0] da_q, da_d;
    logic [15:0] id_q, id_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] csum_q, csum_d;
    logic [16:0] pay_q, pay_d;      // payload nibbles left, including the one on dout
    logic [3:0]  nib_q, nib_d;
    logic        err_q, err_d;

    logic [3:0]  widx;
    logic [15:0] hdr_w;
    logic [3:0]  hdr_nib;
    logic [16:0] sum17;
    logic [15:0] acc_fold;

    // During CSUM the step count skips word 5 (the checksum slot itself).
    always_comb begin
        widx = cnt_q[5:2];
        if (state_q == S_CSUM)
            widx = (cnt_q >= 6'd5) ? (cnt_q[3:0] + 4'd1) : cnt_q[3:0];
    end

    always_comb begin
        hdr_w = 16'h0000;
        case (widx)
            4'd0: hdr_w = 16'h4500;
            4'd1: hdr_w = len_q + 16'd20;
            4'd2: hdr_w = id_q;
            4'd3: hdr_w = {1'b0, DF, 14'b0};
            4'd4: hdr_w = {TTL, proto_q};
            4'd5: hdr_w = csum_q;
            4'd6: hdr_w = sa_q[31:16];
            4'd7: hdr_w = sa_q[15:0];
            4'd8: hdr_w = da_q[31:16];
            4'd9: hdr_w = da_q[15:0];
            default: hdr_w = 16'h0000;
        endcase
    end

    always_comb begin
        case (cnt_q[1:0])
            2'd0: hdr_nib = hdr_w[15:12];
            2'd1: hdr_nib = hdr_w[11:8];
            2'd2: hdr_nib = hdr_w[7:4];
            default: hdr_nib = hdr_w[3:0];
        endcase
    end

    // One's complement add: the end-around carry cannot overflow again.
    assign sum17    = {1'b0, acc_q} + {1'b0, hdr_w};
    assign acc_fold = sum17[15:0] + {15'b0, sum17[16]};

    assign busy       = (state_q != S_IDLE);
    assign dout_valid = (state_q == S_HDR) || (state_q == S_PAYLOAD);
    assign dout       = (state_q == S_HDR)     ? hdr_nib :
                        (state_q == S_PAYLOAD) ? nib_q   : 4'h0;
    assign din_ready  = ((state_q == S_HDR) && (cnt_q == 6'd39) && (len_q != 16'd0)) ||
                        ((state_q == S_PAYLOAD) && (pay_q > 17'd1));
    assign err        = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        proto_d = proto_q;
        sa_d    = sa_q;
        da_d    = da_q;
        id_d    = id_q;
        acc_d   = acc_q;
        csum_d  = csum_q;
        pay_d   = pay_q;
        nib_d   = nib_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (payload_len > MAX_PAYLOAD) begin
                        err_d = 1'b1;
                    end else begin
                        len_d   = payload_len;
                        proto_d = protocol;
                        sa_d    = sa;
                        da_d    = da;
                        acc_d   = 16'h0000;
                        cnt_d   = 6'd0;
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (cnt_q == 6'd9) begin
                    csum_d  = ~acc_q;
                    cnt_d   = 6'd0;
                    state_d = S_HDR;
                end else begin
                    acc_d = acc_fold;
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_HDR: begin
                if (cnt_q == 6'd39) begin
                    if (len_q == 16'd0) begin
                        id_d    = id_q + 16'd1;
                        state_d = S_IDLE;
                    end else if (din_valid) begin
                        nib_d   = din;
                        pay_d   = {len_q, 1'b0};
                        state_d = S_PAYLOAD;
                    end else begin
                        err_d   = 1'b1;
                        id_d    = id_q + 16'd1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_PAYLOAD: begin
                if (pay_q == 17'd1) begin
                    id_d    = id_q + 16'd1;
                    state_d = S_IDLE;
                end else if (din_valid) begin
                    nib_d = din;
                    pay_d = pay_q - 17'd1;
                end else begin
                    err_d   = 1'b1;
                    id_d    = id_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            len_q   <= 16'd0;
            proto_q <= 8'd0;
            sa_q    <= 32'd0;
            da_q    <= 32'd0;
            id_q    <= ID_INIT;
            acc_q   <= 16'd0;
            csum_q  <= 16'd0;
            pay_q   <= 17'd0;
            nib_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            proto_q <= proto_d;
            sa_q    <= sa_d;
            da_q    <= da_d;
            id_q    <= id_d;
            acc_q   <= acc_d;
            csum_q  <= csum_d;
            pay_q   <= pay_d;
            nib_q   <= nib_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_ip_encode.sv
// Testbench for ip_encode: expected nibbles are queued by the stimulus tasks
// from a word-level header model; a negedge monitor pops and compares.
module tb_ip_encode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] payload_len = '0;
    logic [7:0]  protocol = '0;
    logic [31:0] sa = '0;
    logic [31:0] da = '0;
    logic        din_valid = 1'b0;
    logic [3:0]  din = '0;
    logic        din_ready, dout_valid, busy, err;
    logic [3:0]  dout;

    ip_encode dut (
        .clk(clk), .rst(rst), .start(start), .payload_len(payload_len),
        .protocol(protocol), .sa(sa), .da(da), .din_valid(din_valid), .din(din),
        .din_ready(din_ready), .dout_valid(dout_valid), .dout(dout),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0] exp_q[$];
    logic [3:0] src_q[$];
    int   n_cmp = 0, n_bad = 0;
    int   err_cnt = 0, rdy_cnt = 0, first_cyc = 0;
    bit   prev_v = 0, cons = 0, mon_en = 0;
    logic [15:0] tb_id = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Upstream source and output monitor, both on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (cons && src_q.size() > 0) void'(src_q.pop_front());
            din_valid = (src_q.size() > 0);
            din       = (src_q.size() > 0) ? src_q[0] : 4'h0;
            cons      = din_ready && din_valid;
            if (din_ready) rdy_cnt++;
            if (err) err_cnt++;
            if (dout_valid) begin
                if (!prev_v) first_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected nibble: got %0h expected none", dout);
                end else begin
                    chk("nibble", {28'd0, dout}, {28'd0, exp_q.pop_front()});
                end
            end else begin
                chk("dout idle zero", {28'd0, dout}, 32'd0);
                if (prev_v) chk("busy after last nibble", {31'd0, busy}, 32'd0);
            end
            prev_v = dout_valid;
        end
    end

    // len: payload bytes; supply: payload nibbles the source offers;
    // poke: raise start during payload; rst_at: reset after that many cycles.
    task automatic send(input int len, input logic [7:0] pr, input logic [31:0] s,
                        input logic [31:0] d, input int supply, input bit poke,
                        input int rst_at, input bit use_ovr, input logic [159:0] ovr);
        logic [15:0] w[10];
        int  sum, np, e0, r0, scyc, bound;
        bit  acc, done, was_rst;
        logic [3:0] n;
        e0 = err_cnt; r0 = rdy_cnt; was_rst = 0; done = 0;
        acc = (len <= 65515);
        np = (supply < 2 * len) ? supply : 2 * len;
        if (acc) begin
            w[0] = 16'h4500; w[1] = 16'(len + 20); w[2] = tb_id; w[3] = 16'h4000;
            w[4] = {8'd64, pr}; w[5] = 16'h0000;
            w[6] = s[31:16]; w[7] = s[15:0]; w[8] = d[31:16]; w[9] = d[15:0];
            sum = 0;
            for (int i = 0; i < 10; i++) sum += int'(w[i]);
            while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
            w[5] = ~sum[15:0];
            if (use_ovr) for (int i = 0; i < 10; i++) w[i] = ovr[159 - 16 * i -: 16];
            for (int i = 0; i < 10; i++)
                for (int j = 3; j >= 0; j--) exp_q.push_back(w[i][4 * j +: 4]);
            for (int k = 0; k < np; k++) begin
                n = 4'($urandom_range(15, 0));
                src_q.push_back(n);
                exp_q.push_back(n);
            end
        end
        @(negedge clk);
        payload_len = 16'(len); protocol = pr; sa = s; da = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scyc = cyc;
        if (!acc) begin
            chk("reject err pulse", {31'd0, err}, 32'd1);
            chk("reject busy", {31'd0, busy}, 32'd0);
        end
        bound = 2 * len + 200;
        for (int t = 0; t < bound; t++) begin
            if (!busy) begin done = 1; break; end
            if (rst_at > 0 && t == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst dout_valid", {31'd0, dout_valid}, 32'd0);
                chk("rst dout", {28'd0, dout}, 32'd0);
                chk("rst busy", {31'd0, busy}, 32'd0);
                chk("rst din_ready", {31'd0, din_ready}, 32'd0);
                exp_q.delete(); src_q.delete();
                tb_id = 16'h0000;
                was_rst = 1; done = 1;
                break;
            end
            if (poke && t == 60) begin
                payload_len = 16'd3; protocol = 8'hAA; start = 1'b1;
            end
            if (poke && t == 61) start = 1'b0;
            @(negedge clk);
        end
        if (!done) chk("packet timeout", 32'd1, 32'd0);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("all nibbles seen", exp_q.size(), 0);
        chk("source drained", src_q.size(), 0);
        if (acc && !was_rst) begin
            chk("first valid latency", first_cyc - scyc, 10);
            tb_id = tb_id + 16'd1;
        end
        chk("err pulses", err_cnt - e0, (!acc || (!was_rst && np < 2 * len)) ? 1 : 0);
        if (len == 0) chk("din_ready never high", rdy_cnt - r0, 0);
    endtask

    initial begin
        logic [159:0] known;
        int len;
        known = 160'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset dout_valid", {31'd0, dout_valid}, 32'd0);
        chk("reset dout", {28'd0, dout}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset err", {31'd0, err}, 32'd0);
        chk("reset din_ready", {31'd0, din_ready}, 32'd0);
        mon_en = 1;

        // known header, with a start raised during payload that must be ignored
        send(95, 8'h11, 32'hC0A80001, 32'hC0A800C7, 190, 1, 0, 1, known);
        // back-to-back: ID 0001, recomputed checksum
        send(30, 8'h01, $urandom, $urandom, 60, 0, 0, 0, '0);
        // empty payload
        send(0, 8'h11, $urandom, $urandom, 0, 0, 0, 0, '0);
        // length limits
        send(65516, 8'h11, $urandom, $urandom, 0, 0, 0, 0, '0);
        send(65515, 8'h11, $urandom, $urandom, 0, 0, 0, 0, '0);
        // underflow at payload nibble 7, then a normal packet with ID+1
        send(20, 8'h06, $urandom, $urandom, 7, 0, 0, 0, '0);
        send(10, 8'h11, $urandom, $urandom, 20, 0, 0, 0, '0);
        // reset mid-header, then ID restarts at ID_INIT
        send(20, 8'h11, $urandom, $urandom, 40, 0, 25, 0, '0);
        send(5, 8'h11, $urandom, $urandom, 10, 0, 0, 0, '0);
        for (int p = 0; p < 4; p++) begin
            len = $urandom_range(40, 1);
            send(len, 8'($urandom), $urandom, $urandom, 2 * len, 0, 0, 0, '0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
